// File: rtl/rtc_field_commit.sv
// Commits one user-edited BCD time field to the RTC over a req/ack write handshake.
// Define RTC_READBACK_EN to add a read-back-and-compare step after the write.
module rtc_field_commit #(
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] field_i,
  input  logic [7:0] value_i,
  input  logic       commit_i,
  input  logic       wr_ack_i,
`ifdef RTC_READBACK_EN
  output logic       rd_req_o,
  input  logic       rd_ack_i,
  input  logic [7:0] rd_data_i,
`endif
  output logic       wr_req_o,
  output logic [7:0] addr_o,
  output logic [7:0] data_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WREQ,
`ifdef RTC_READBACK_EN
    S_RDREQ,
    S_RCMP,
`endif
    S_DONE
  } state_t;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(ACK_TIMEOUT);

  state_t          r_state;
  state_t          w_next;
  logic            r_commit_q;
  logic [3:0]      r_field;
  logic [7:0]      r_addr;
  logic [7:0]      r_data;
  logic [TO_W-1:0] r_to_cnt;

  logic       w_edge;
  logic       w_expired;
  logic       w_latch;
  logic       w_cnt_clr;
  logic       w_cnt_inc;
  logic       w_err;
  logic       w_valid;
  logic       w_fld_ok;
  logic [7:0] w_min;
  logic [7:0] w_max;
  logic [7:0] w_addr_map;

`ifdef RTC_READBACK_EN
  logic [7:0] r_rd_data;
  logic       w_rd_cap;
`endif

  assign w_edge    = commit_i & ~r_commit_q;
  assign w_expired = (r_to_cnt == TO_LIMIT);

  always_comb begin
    w_addr_map = '0;
    case (field_i)
      4'd1:    w_addr_map = 8'h21;
      4'd2:    w_addr_map = 8'h22;
      4'd3:    w_addr_map = 8'h23;
      4'd4:    w_addr_map = 8'h24;
      4'd5:    w_addr_map = 8'h25;
      4'd6:    w_addr_map = 8'h26;
      4'd7:    w_addr_map = 8'h43;
      4'd8:    w_addr_map = 8'h42;
      4'd9:    w_addr_map = 8'h41;
      default: w_addr_map = '0;
    endcase
  end

  // With both nibbles <= 9, plain unsigned compare of packed BCD orders like decimal.
  always_comb begin
    w_fld_ok = 1'b1;
    w_min    = 8'h00;
    w_max    = 8'h59;
    case (r_field)
      4'd1, 4'd2, 4'd8, 4'd9: w_max = 8'h59;
      4'd3, 4'd7:             w_max = 8'h23;
      4'd4: begin
        w_min = 8'h01;
        w_max = 8'h31;
      end
      4'd5: begin
        w_min = 8'h01;
        w_max = 8'h12;
      end
      4'd6:                   w_max = 8'h99;
      default:                w_fld_ok = 1'b0;
    endcase
    w_valid = w_fld_ok && (r_data[7:4] <= 4'd9) && (r_data[3:0] <= 4'd9) &&
              (r_data >= w_min) && (r_data <= w_max);
  end

  always_comb begin
    w_next    = r_state;
    w_latch   = 1'b0;
    w_cnt_clr = 1'b0;
    w_cnt_inc = 1'b0;
    w_err     = 1'b0;
`ifdef RTC_READBACK_EN
    w_rd_cap  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_edge) begin
          w_latch = 1'b1;
          w_next  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_valid) begin
          w_cnt_clr = 1'b1;
          w_next    = S_WREQ;
        end else begin
          w_err  = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_WREQ: begin
        // An ack arriving on the expiry cycle still completes the write.
        if (wr_ack_i) begin
`ifdef RTC_READBACK_EN
          w_cnt_clr = 1'b1;
          w_next    = S_RDREQ;
`else
          w_next    = S_DONE;
`endif
        end else if (w_expired) begin
          w_err  = 1'b1;
          w_next = S_IDLE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
`ifdef RTC_READBACK_EN
      S_RDREQ: begin
        if (rd_ack_i) begin
          w_rd_cap = 1'b1;
          w_next   = S_RCMP;
        end else if (w_expired) begin
          w_err  = 1'b1;
          w_next = S_IDLE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_RCMP: begin
        if (r_rd_data == r_data) begin
          w_next = S_DONE;
        end else begin
          w_err  = 1'b1;
          w_next = S_IDLE;
        end
      end
`endif
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_commit_q <= 1'b0;
      r_field    <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_to_cnt   <= '0;
    end else begin
      r_state    <= w_next;
      r_commit_q <= commit_i;
      if (w_latch) begin
        r_field <= field_i;
        r_addr  <= w_addr_map;
        r_data  <= value_i;
      end
      if (w_cnt_clr) begin
        r_to_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
    end
  end

`ifdef RTC_READBACK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_data <= '0;
    end else if (w_rd_cap) begin
      r_rd_data <= rd_data_i;
    end
  end

  assign rd_req_o = (r_state == S_RDREQ);
`endif

  assign wr_req_o = (r_state == S_WREQ);
  assign addr_o   = r_addr;
  assign data_o   = r_data;
  assign busy_o   = (r_state != S_IDLE);
  assign done_o   = (r_state == S_DONE);
  assign err_o    = w_err;

endmodule

// File: tb/tb_rtc_field_commit.sv
// Randomized self-checking bench for rtc_field_commit (default build, no read-back).
module tb_rtc_field_commit;

  localparam int unsigned TO = 255;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] field_i;
  logic [7:0] value_i;
  logic       commit_i;
  logic       wr_ack_i;
  logic       wr_req_o;
  logic [7:0] addr_o;
  logic [7:0] data_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  int n_cmp = 0;
  int n_bad = 0;

  rtc_field_commit #(
    .ACK_TIMEOUT(TO),
    .TO_W       (8)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .field_i (field_i),
    .value_i (value_i),
    .commit_i(commit_i),
    .wr_ack_i(wr_ack_i),
    .wr_req_o(wr_req_o),
    .addr_o  (addr_o),
    .data_o  (data_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .err_o   (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: decimal value of the two BCD digits checked against each field's calendar range.
  function automatic bit model_valid(input int f, input int v);
    int tens;
    int units;
    int n;
    tens  = v / 16;
    units = v % 16;
    if (tens > 9 || units > 9) return 1'b0;
    n = tens * 10 + units;
    if (f == 1 || f == 2 || f == 8 || f == 9) return n <= 59;
    if (f == 3 || f == 7) return n <= 23;
    if (f == 4) return n >= 1 && n <= 31;
    if (f == 5) return n >= 1 && n <= 12;
    if (f == 6) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_addr(input int f);
    int tbl[10] = '{0, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h43, 'h42, 'h41};
    return (f >= 1 && f <= 9) ? tbl[f] : 0;
  endfunction

  // One commit; ack_dly = WREQ cycles before ack. second_edge needs ack_dly >= 2.
  task automatic do_commit(input int f, input int v, input int ack_dly, input bit second_edge);
    bit ok;
    int ea;
    ok = model_valid(f, v);
    ea = model_addr(f);
    field_i  = 4'(f);
    value_i  = 8'(v);
    commit_i = 1'b1;
    tick();
    chk_eq("chk_busy", busy_o, 1);
    chk_eq("chk_req", wr_req_o, 0);
    chk_eq("chk_err", err_o, {31'd0, !ok});
    field_i  = 4'($urandom);
    value_i  = 8'($urandom);
    commit_i = 1'b0;
    tick();
    if (!ok) begin
      chk_eq("inv_req", wr_req_o, 0);
      chk_eq("inv_busy", busy_o, 0);
      chk_eq("inv_err", err_o, 0);
      chk_eq("inv_done", done_o, 0);
      return;
    end
    for (int i = 0; i < ack_dly; i++) begin
      chk_eq("wreq_req", wr_req_o, 1);
      chk_eq("wreq_done", done_o, 0);
      chk_eq("wreq_err", err_o, 0);
      if (i == 0) begin
        chk_eq("wreq_addr", addr_o, ea);
        chk_eq("wreq_data", data_o, v);
      end
      if (second_edge && i == 0) commit_i = 1'b1;
      if (second_edge && i == 1) commit_i = 1'b0;
      field_i = 4'($urandom);
      value_i = 8'($urandom);
      tick();
    end
    chk_eq("ack_req", wr_req_o, 1);
    chk_eq("ack_addr", addr_o, ea);
    chk_eq("ack_data", data_o, v);
    wr_ack_i = 1'b1;
    tick();
    wr_ack_i = 1'b0;
    chk_eq("done_pulse", done_o, 1);
    chk_eq("done_req", wr_req_o, 0);
    chk_eq("done_err", err_o, 0);
    tick();
    chk_eq("post_done", done_o, 0);
    chk_eq("post_busy", busy_o, 0);
    tick();
    chk_eq("idle_busy", busy_o, 0);
    chk_eq("idle_req", wr_req_o, 0);
    chk_eq("idle_addr", addr_o, ea);
    chk_eq("idle_data", data_o, v);
  endtask

  task automatic do_timeout(input int f, input int v);
    int n;
    int err_at;
    field_i  = 4'(f);
    value_i  = 8'(v);
    commit_i = 1'b1;
    tick();
    commit_i = 1'b0;
    tick();
    n = 0;
    err_at = -1;
    while (wr_req_o === 1'b1 && n < int'(TO) + 5) begin
      n++;
      if (err_o === 1'b1 && err_at < 0) err_at = n;
      tick();
    end
    chk_eq("to_req_len", n, TO + 1);
    chk_eq("to_err_cycle", err_at, TO + 1);
    chk_eq("to_busy", busy_o, 0);
    chk_eq("to_err_after", err_o, 0);
  endtask

  initial begin
    int f;
    int v;
    int d;
    rst_n    = 1'b0;
    field_i  = '0;
    value_i  = '0;
    commit_i = 1'b0;
    wr_ack_i = 1'b0;
    #3;
    chk_eq("rst_req", wr_req_o, 0);
    chk_eq("rst_busy", busy_o, 0);
    chk_eq("rst_done", done_o, 0);
    chk_eq("rst_err", err_o, 0);
    chk_eq("rst_addr", addr_o, 0);
    chk_eq("rst_data", data_o, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    do_commit(3, 'h15, 2, 0);
    do_commit(5, 'h13, 0, 0);
    do_commit(4, 'h00, 0, 0);
    do_commit(1, 'h5A, 0, 0);
    do_timeout(2, 'h59);

    wr_ack_i = 1'b1;
    tick();
    wr_ack_i = 1'b0;
    chk_eq("idle_ack_done", done_o, 0);
    chk_eq("idle_ack_busy", busy_o, 0);
    tick();
    chk_eq("idle_ack_req", wr_req_o, 0);

    do_commit(2, 'h45, 3, 1);
    do_commit(6, 'h99, TO, 0);
    do_commit(4, 'h31, 1, 0);
    do_commit(4, 'h32, 0, 0);
    do_commit(5, 'h12, 0, 0);
    do_commit(3, 'h23, 1, 0);
    do_commit(3, 'h24, 0, 0);
    do_commit(7, 'h24, 0, 0);
    do_commit(9, 'h59, 2, 0);
    do_commit(8, 'h60, 0, 0);
    do_commit(0, 'h00, 0, 0);
    do_commit(10, 'h00, 0, 0);

    field_i  = 4'd1;
    value_i  = 8'h30;
    commit_i = 1'b1;
    tick();
    commit_i = 1'b0;
    tick();
    chk_eq("mid_req", wr_req_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("mid_rst_req", wr_req_o, 0);
    chk_eq("mid_rst_busy", busy_o, 0);
    chk_eq("mid_rst_addr", addr_o, 0);
    tick();
    rst_n = 1'b1;
    tick();
    do_commit(1, 'h30, 1, 0);

    for (int k = 0; k < 60; k++) begin
      f = int'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 255));
      else v = int'($urandom_range(0, 9)) * 16 + int'($urandom_range(0, 9));
      d = int'($urandom_range(0, 4));
      if ($urandom_range(0, 4) == 0) begin
        wr_ack_i = 1'b1;
        tick();
        wr_ack_i = 1'b0;
        chk_eq("rnd_idle_ack", done_o, 0);
      end
      do_commit(f, v, d, d >= 2 && $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
